// File: rtl/pci_pkg.sv
// Shared PCI target definitions: bus command codes, target FSM states and
// the byte-enable helper used by the memory write port.
package pci_pkg;

  localparam logic [3:0] CMD_MEMRD = 4'b0110;
  localparam logic [3:0] CMD_MEMWR = 4'b0111;

  typedef enum logic [1:0] {IDLE, TURN, DATA, BACKOFF} tgt_state_t;

  // Bus byte enables are active low; the register file wants an active-high mask.
  function automatic logic [3:0] be_to_mask(input logic [3:0] c_be_n);
    return ~c_be_n;
  endfunction

endpackage

// File: rtl/pci_tgt_mem.sv
// DEPTH x 32 register file: async clear, one byte-masked write port and one
// combinational read port.
module pci_tgt_mem #(
  parameter int unsigned DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     we_i,
  input  logic [$clog2(DEPTH)-1:0] waddr_i,
  input  logic [3:0]               wmask_i,
  input  logic [31:0]              wdata_i,
  input  logic [$clog2(DEPTH)-1:0] raddr_i,
  output logic [31:0]              rdata_c_o
);

  logic [31:0] mem_q [DEPTH];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int unsigned i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else if (we_i) begin
      for (int unsigned b = 0; b < 4; b++) begin
        if (wmask_i[b]) mem_q[waddr_i][8*b +: 8] <= wdata_i[8*b +: 8];
      end
    end
  end

  assign rdata_c_o = mem_q[raddr_i];

endmodule

// File: rtl/pci_mem_target.sv
// Memory-backed PCI target for single and burst MemRd/MemWr to a word window.
// Define PCI_TGT_WAIT_EN to insert WAIT_CYCLES TRDY_ wait states per data phase.
module pci_mem_target
  import pci_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR   = 32'h0000_0100,
  parameter int unsigned DEPTH       = 16,
  parameter int unsigned WAIT_CYCLES = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        FRAME_,
  input  logic        IRDY_,
  input  logic [3:0]  C_BE_,
  inout  wire  [31:0] AD,
  output logic        TRDY_,
  output logic        DEVSEL_
);

  localparam int unsigned ADDR_W = $clog2(DEPTH);

  tgt_state_t        state_q;
  logic [ADDR_W-1:0] ptr_q;
  logic              rd_q;
  logic              frame_prev_q;
  logic              drv_q;
  logic              trdy_q;
  logic              devsel_q;
  logic              hit_c;
  logic              xfer_c;
  logic              wait_done_c;
  logic [31:0]       rdata_c;

  assign hit_c  = (AD[31:ADDR_W+2] == BASE_ADDR[31:ADDR_W+2]) &&
                  ((C_BE_ == CMD_MEMRD) || (C_BE_ == CMD_MEMWR));
  assign xfer_c = (state_q == DATA) && !trdy_q && !IRDY_;

`ifdef PCI_TGT_WAIT_EN
  localparam int unsigned WCNT_W    = (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES) : 1;
  localparam int unsigned WAIT_LOAD = (WAIT_CYCLES > 0) ? WAIT_CYCLES - 1 : 0;
  localparam logic        TRDY_ENTRY = (WAIT_CYCLES != 0);

  logic [WCNT_W-1:0] wait_q;
  logic              waiting_c;

  // Counter rearms whenever TRDY_ is not being held off, counts down while it is.
  assign waiting_c   = (state_q == DATA) && trdy_q;
  assign wait_done_c = (wait_q == '0);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wait_q <= WCNT_W'(WAIT_LOAD);
    end else if (!waiting_c) begin
      wait_q <= WCNT_W'(WAIT_LOAD);
    end else if (!wait_done_c) begin
      wait_q <= wait_q - WCNT_W'(1);
    end
  end
`else
  localparam logic TRDY_ENTRY = 1'b0;
  // WAIT_CYCLES has no effect without wait states.
  wire unused_wait_cfg = |WAIT_CYCLES;
  assign wait_done_c = 1'b1;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= IDLE;
      ptr_q        <= '0;
      rd_q         <= 1'b0;
      frame_prev_q <= 1'b1;
      drv_q        <= 1'b0;
      trdy_q       <= 1'b1;
      devsel_q     <= 1'b1;
    end else begin
      frame_prev_q <= FRAME_;
      unique case (state_q)
        IDLE: begin
          if (!FRAME_ && frame_prev_q && hit_c) begin
            ptr_q    <= AD[ADDR_W+1:2];
            rd_q     <= (C_BE_ == CMD_MEMRD);
            devsel_q <= 1'b0;
            if (C_BE_ == CMD_MEMRD) begin
              state_q <= TURN;
            end else begin
              state_q <= DATA;
              trdy_q  <= TRDY_ENTRY;
            end
          end
        end
        TURN: begin
          if (FRAME_ && IRDY_) begin
            state_q  <= BACKOFF;
            devsel_q <= 1'b1;
          end else begin
            state_q <= DATA;
            drv_q   <= 1'b1;
            trdy_q  <= TRDY_ENTRY;
          end
        end
        DATA: begin
          if (xfer_c) begin
            ptr_q <= ptr_q + ADDR_W'(1);
            if (FRAME_) begin
              state_q  <= BACKOFF;
              trdy_q   <= 1'b1;
              devsel_q <= 1'b1;
              drv_q    <= 1'b0;
            end else begin
              trdy_q <= TRDY_ENTRY;
            end
          end else if (FRAME_ && IRDY_) begin
            // Initiator disappeared without completing the phase.
            state_q  <= BACKOFF;
            trdy_q   <= 1'b1;
            devsel_q <= 1'b1;
            drv_q    <= 1'b0;
          end else if (trdy_q && wait_done_c) begin
            trdy_q <= 1'b0;
          end
        end
        BACKOFF: state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

  pci_tgt_mem #(.DEPTH(DEPTH)) u_mem (
    .clk       (clk),
    .reset     (reset),
    .we_i      (xfer_c && !rd_q),
    .waddr_i   (ptr_q),
    .wmask_i   (be_to_mask(C_BE_)),
    .wdata_i   (AD),
    .raddr_i   (ptr_q),
    .rdata_c_o (rdata_c)
  );

  assign AD      = drv_q ? rdata_c : 'z;
  assign TRDY_   = trdy_q;
  assign DEVSEL_ = devsel_q;

endmodule
